// File: rtl/interfaz_pkg.sv
// Definitions shared by the debug-link UART interfaces (word transmit and receive sides):
// FSM states, data widths and the default ASCII offset.
package interfaz_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // The receive side subtracts this same offset, so keep both sides on one definition.
  localparam logic [BYTE_W-1:0] DEFAULT_ASCII_OFFSET = 8'd48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_word_tx.sv
// Serialises 32-bit words into ASCII-offset bytes, MSB first, over a start/done UART handshake,
// and counts the completed words on tx_address.
module uart_word_tx
  import interfaz_pkg::*;
#(
  parameter int unsigned       BYTES_PER_WORD = 4,
  parameter logic [BYTE_W-1:0] ASCII_OFFSET   = DEFAULT_ASCII_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              sent,
  output logic [WORD_W-1:0] tx_address
);

  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  tx_state_e         state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              sent_q;
  logic              word_ready_q;
  logic              busy_q;
  logic [WORD_W-1:0] tx_address_q;

  // NOTE: every register here is written with <= so all updates in a cycle see the
  // pre-edge values; blocking assignments would make the shift/offset order-dependent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      sent_q       <= 1'b0;
      word_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      tx_address_q <= '0;
    end else begin
      tx_start_q <= 1'b0;
      sent_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (word_valid) begin
            state_q      <= ISSUE;
            shreg_q      <= word_data;
            cnt_q        <= '0;
            tx_data_q    <= word_data[WORD_W-1 -: BYTE_W] + ASCII_OFFSET;
            tx_start_q   <= 1'b1;
            word_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (tx_done) begin
            if (cnt_q == LAST_IDX) begin
              state_q <= DONE;
              sent_q  <= 1'b1;
            end else begin
              // The byte after the current one sits just below the top of the shift register.
              state_q    <= ISSUE;
              shreg_q    <= shreg_q << BYTE_W;
              cnt_q      <= cnt_q + 1'b1;
              tx_data_q  <= shreg_q[WORD_W-BYTE_W-1 -: BYTE_W] + ASCII_OFFSET;
              tx_start_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          tx_address_q <= tx_address_q + 1'b1;
          word_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign word_ready = word_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign sent       = sent_q;
  assign tx_address = tx_address_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: UART responder models, a byte-list reference model and one task per scenario.
module tb_uart_word_tx;
  import interfaz_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Main DUT (defaults: 4 bytes, offset 48)
  logic        word_valid, word_ready, tx_start, busy, sent;
  logic [31:0] word_data, tx_address;
  logic [7:0]  tx_data;
  logic        uart_done, spur_done, tx_done;
  assign tx_done = uart_done | spur_done;

  uart_word_tx dut (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .sent(sent), .tx_address(tx_address)
  );

  // Variant DUT: 2 bytes per word, no offset
  logic        w2_valid, w2_ready, w2_start, w2_done, w2_busy, w2_sent;
  logic [31:0] w2_data, w2_addr;
  logic [7:0]  w2_txd;

  uart_word_tx #(.BYTES_PER_WORD(2), .ASCII_OFFSET(8'd0)) dut2 (
    .clk(clk), .reset(reset), .word_valid(w2_valid), .word_data(w2_data),
    .word_ready(w2_ready), .tx_start(w2_start), .tx_data(w2_txd), .tx_done(w2_done),
    .busy(w2_busy), .sent(w2_sent), .tx_address(w2_addr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: byte k of a word is bits [31-8k -: 8] plus the offset, modulo 256.
  function automatic byte_q_t ref_bytes(input logic [31:0] w, input int bpw, input logic [7:0] off);
    byte_q_t q;
    logic [7:0] b;
    for (int i = 0; i < bpw; i++) begin
      b = w[31-8*i -: 8];
      q.push_back(8'(b + off));
    end
    return q;
  endfunction

  // UART model for the main DUT: tx_done comes uart_delay cycles after each tx_start.
  int      uart_delay = 10;
  byte_q_t cap;
  int      start_cycs[$];
  int      cnt1 = 0;
  logic [7:0] held = '0;
  bit      hold_chk = 0;
  int      done_cyc = 0, sent_cyc = 0, ready_cyc = 0, sent_cnt = 0;
  logic    prev_ready = 1'b1;

  initial begin
    uart_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      uart_done = 1'b0;
      if (reset) hold_chk = 0;
      else begin
        if (hold_chk) begin
          n_cmp++;
          if (tx_data !== held) begin
            n_err++;
            $display("FAIL tx_data_hold: got %h want %h (cycle %0d)", tx_data, held, cyc);
          end
        end
        n_cmp++;
        if (word_ready !== ~busy) begin
          n_err++;
          $display("FAIL ready_vs_busy: word_ready %b busy %b (cycle %0d)", word_ready, busy, cyc);
        end
        if (sent === 1'b1) begin
          sent_cnt++;
          sent_cyc = cyc;
        end
        if (word_ready && !prev_ready) ready_cyc = cyc;
      end
      prev_ready = word_ready;
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          uart_done = 1'b1;
          done_cyc  = cyc;
          hold_chk  = 0;
        end
      end
      if (tx_start === 1'b1 && !reset) begin
        held = tx_data;
        cap.push_back(tx_data);
        start_cycs.push_back(cyc);
        hold_chk = 1;
        cnt1 = uart_delay;
      end
    end
  end

  // UART model for the variant DUT: fixed 3-cycle byte time.
  byte_q_t cap2;
  int      cnt2 = 0;
  initial begin
    w2_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      w2_done = 1'b0;
      if (cnt2 > 0) begin
        cnt2--;
        if (cnt2 == 0) w2_done = 1'b1;
      end
      if (w2_start === 1'b1 && !reset) begin
        cap2.push_back(w2_txd);
        cnt2 = 3;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    word_valid = 1'b0;
    spur_done = 1'b0;
    w2_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cap.delete();
    start_cycs.delete();
    sent_cnt = 0;
  endtask

  // Offer one word; start_seen reports tx_start in the cycle after the accept edge.
  task automatic send_word(input logic [31:0] w, output bit ok, output logic start_seen);
    int budget = 200;
    ok = 0;
    start_seen = 1'b0;
    while (word_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) return;
    word_valid = 1'b1;
    word_data  = w;
    @(negedge clk);
    word_valid = 1'b0;
    word_data  = $urandom;
    start_seen = tx_start;
    ok = 1;
  endtask

  task automatic wait_sent(output bit ok);
    int budget = 2000;
    ok = 0;
    while (budget > 0) begin
      @(negedge clk);
      budget--;
      if (sent === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    word_valid = 1'b0; word_data = '0; spur_done = 1'b0;
    w2_valid = 1'b0; w2_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp += 7;
    if (word_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", word_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", tx_start); end
    if (sent !== 1'b0) begin n_err++; $display("FAIL reset_sent: got %b want 0", sent); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", tx_data); end
    if (tx_address !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", tx_address); end
    if (w2_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready2: got %b want 1", w2_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok, ok2;
    logic st;
    byte_q_t exp;
    do_reset();
    uart_delay = 10;
    send_word(32'h01020304, ok, st);
    wait_sent(ok2);
    exp = ref_bytes(32'h01020304, 4, 8'd48);
    n_cmp += 4;
    if (!(ok && ok2)) begin n_err++; $display("FAIL single_handshake: accepted %b sent %b want 1 1", ok, ok2); end
    if (st !== 1'b1) begin n_err++; $display("FAIL single_start_latency: tx_start %b want 1", st); end
    if (cap.size() != exp.size()) begin n_err++; $display("FAIL single_count: got %0d want %0d", cap.size(), exp.size()); end
    if (sent_cnt != 1) begin n_err++; $display("FAIL single_sent_pulses: got %0d want 1", sent_cnt); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp[i]) begin n_err++; $display("FAIL single_byte%0d: got %h want %h", i, cap[i], exp[i]); end
    end
    n_cmp += 3;
    if (tx_address !== 32'd1) begin n_err++; $display("FAIL single_addr: got %0d want 1", tx_address); end
    if (sent_cyc != done_cyc + 1) begin n_err++; $display("FAIL single_sent_timing: got cycle %0d want %0d", sent_cyc, done_cyc + 1); end
    if (ready_cyc != done_cyc + 2) begin n_err++; $display("FAIL single_ready_timing: got cycle %0d want %0d", ready_cyc, done_cyc + 2); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int budget = 500;
    int d;
    byte_q_t exp;
    do_reset();
    d = $urandom_range(1, 8);
    uart_delay = d;
    word_valid = 1'b1;
    word_data  = 32'h0A0B0C0D;
    @(negedge clk);
    word_data  = 32'h00000000;
    @(negedge clk);
    while (word_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    word_valid = 1'b0;
    wait_sent(ok);
    exp = ref_bytes(32'h0A0B0C0D, 4, 8'd48);
    exp = {exp, ref_bytes(32'h00000000, 4, 8'd48)};
    n_cmp += 4;
    if (!ok || budget == 0) begin n_err++; $display("FAIL b2b_handshake: ok %b budget %0d want 1 and >0", ok, budget); end
    if (cap.size() != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", cap.size()); end
    if (sent_cnt != 2) begin n_err++; $display("FAIL b2b_sent_pulses: got %0d want 2", sent_cnt); end
    if (tx_address !== 32'd2) begin n_err++; $display("FAIL b2b_addr: got %0d want 2", tx_address); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, cap[i], exp[i]); end
    end
    if (start_cycs.size() >= 5) begin
      n_cmp++;
      if (start_cycs[4] - start_cycs[0] != 2 + 4 * (1 + d)) begin
        n_err++;
        $display("FAIL b2b_word_period: got %0d want %0d", start_cycs[4] - start_cycs[0], 2 + 4 * (1 + d));
      end
    end
  endtask

  task automatic test_spurious();
    bit ok;
    logic [31:0] w;
    byte_q_t exp;
    int budget;
    do_reset();
    uart_delay = $urandom_range(2, 6);
    repeat (3) begin
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
    end
    n_cmp += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL spur_idle_busy: got %b want 0", busy); end
    if (tx_start !== 1'b0) begin n_err++; $display("FAIL spur_idle_start: got %b want 0", tx_start); end
    if (cap.size() != 0) begin n_err++; $display("FAIL spur_idle_bytes: got %0d want 0", cap.size()); end
    w = $urandom;
    word_valid = 1'b1;
    word_data  = w;
    @(negedge clk);
    word_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      budget = 100;
      while (tx_start !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
    end
    wait_sent(ok);
    exp = ref_bytes(w, 4, 8'd48);
    n_cmp += 3;
    if (!ok) begin n_err++; $display("FAIL spur_sent: got 0 want 1"); end
    if (cap.size() != 4) begin n_err++; $display("FAIL spur_count: got %0d want 4", cap.size()); end
    if (tx_address !== 32'd1) begin n_err++; $display("FAIL spur_addr: got %0d want 1", tx_address); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp[i]) begin n_err++; $display("FAIL spur_byte%0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    logic st;
    int budget = 300;
    bit saw_sent = 0;
    byte_q_t exp;
    do_reset();
    uart_delay = 10;
    send_word(32'hFFFFFFFF, ok, st);
    while (cap.size() < 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp += 7;
    if (budget == 0) begin n_err++; $display("FAIL rst_mid_reach: third byte not seen"); end
    if (word_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", word_ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_mid_start: got %b want 0", tx_start); end
    if (sent !== 1'b0) begin n_err++; $display("FAIL rst_mid_sent: got %b want 0", sent); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", tx_data); end
    if (tx_address !== 32'h0) begin n_err++; $display("FAIL rst_mid_addr: got %h want 0", tx_address); end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sent === 1'b1 || busy !== 1'b0) saw_sent = 1;
    end
    n_cmp += 2;
    if (saw_sent) begin n_err++; $display("FAIL rst_mid_quiet: activity after reset, want none"); end
    if (tx_address !== 32'h0) begin n_err++; $display("FAIL rst_mid_addr_after: got %h want 0", tx_address); end
    cap.delete();
    send_word(32'hFFFFFFFF, ok, st);
    wait_sent(ok2);
    exp = ref_bytes(32'hFFFFFFFF, 4, 8'd48);
    n_cmp += 3;
    if (!(ok && ok2)) begin n_err++; $display("FAIL rst_mid_resend: accepted %b sent %b want 1 1", ok, ok2); end
    if (cap.size() != 4) begin n_err++; $display("FAIL rst_mid_count: got %0d want 4", cap.size()); end
    if (tx_address !== 32'd1) begin n_err++; $display("FAIL rst_mid_addr_final: got %0d want 1", tx_address); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp[i]) begin n_err++; $display("FAIL rst_mid_byte%0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_param_variant();
    int budget = 200;
    byte_q_t exp;
    do_reset();
    cap2.delete();
    w2_valid = 1'b1;
    w2_data  = 32'hDEADBEEF;
    @(negedge clk);
    w2_valid = 1'b0;
    w2_data  = $urandom;
    while (w2_sent !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    exp = ref_bytes(32'hDEADBEEF, 2, 8'd0);
    n_cmp += 4;
    if (budget == 0) begin n_err++; $display("FAIL var_sent: no sent pulse"); end
    if (cap2.size() != 2) begin n_err++; $display("FAIL var_count: got %0d want 2", cap2.size()); end
    if (w2_addr !== 32'd1) begin n_err++; $display("FAIL var_addr: got %0d want 1", w2_addr); end
    if (w2_busy !== 1'b0) begin n_err++; $display("FAIL var_busy: got %b want 0", w2_busy); end
    for (int i = 0; i < exp.size() && i < cap2.size(); i++) begin
      n_cmp++;
      if (cap2[i] !== exp[i]) begin n_err++; $display("FAIL var_byte%0d: got %h want %h", i, cap2[i], exp[i]); end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok, ok2;
    logic st;
    do_reset();
    uart_delay = $urandom_range(1, 5);
    force dut.tx_address_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.tx_address_q;
    @(negedge clk);
    n_cmp++;
    if (tx_address !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffffffff", tx_address); end
    send_word($urandom, ok, st);
    wait_sent(ok2);
    n_cmp += 2;
    if (!(ok && ok2)) begin n_err++; $display("FAIL wrap_send: accepted %b sent %b want 1 1", ok, ok2); end
    if (tx_address !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", tx_address); end
  endtask

  task automatic test_random_words();
    bit ok, ok2;
    logic st;
    logic [31:0] w;
    byte_q_t exp;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      uart_delay = $urandom_range(1, 12);
      w = $urandom;
      exp = {exp, ref_bytes(w, 4, 8'd48)};
      send_word(w, ok, st);
      wait_sent(ok2);
      n_cmp++;
      if (!(ok && ok2 && st === 1'b1)) begin
        n_err++;
        $display("FAIL rand_word%0d_handshake: accepted %b start %b sent %b want 1 1 1", k, ok, st, ok2);
      end
    end
    n_cmp += 3;
    if (cap.size() != exp.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", cap.size(), exp.size()); end
    if (sent_cnt != 6) begin n_err++; $display("FAIL rand_sent_pulses: got %0d want 6", sent_cnt); end
    if (tx_address !== 32'd6) begin n_err++; $display("FAIL rand_addr: got %0d want 6", tx_address); end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      n_cmp++;
      if (cap[i] !== exp[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_param_variant();
    test_addr_wrap();
    test_random_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side companion to the debug link's receive interface. Accepts 32-bit words from the MIPS debug/dump logic over a valid/ready handshake and sends each word to the UART transmitter as a sequence of bytes. Bytes go out MSB-first, one byte per UART handshake, with an ASCII offset added to each byte; this mirrors the receive side's subtraction. Counts completed words on an address output.

## Interface
Parameters:
- BYTES_PER_WORD, 4: bytes per word. Legal values are 1..4; the word is consumed from bit 31 downward.
- ASCII_OFFSET, 8'd48: added modulo 256 to every byte before transmission.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- word_valid  in  1  producer has a word on word_data.
- word_data  in  32  word to send.
- word_ready  out  1  block can accept a word (high only in IDLE).
- tx_start  out  1  one-cycle request to the UART TX to send tx_data.
- tx_data  out  8  byte to send. Stable from the tx_start cycle until tx_done.
- tx_done  in  1  one-cycle pulse from the UART TX when the byte has finished.
- busy  out  1  high in every state except IDLE.
- sent  out  1  one-cycle pulse after the last byte of a word completes.
- tx_address  out  32  count of words fully sent. Wraps modulo 2^32.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Encoded in the package.
- IDLE
  - word_ready=1.
  - When word_valid is high: latch word_data into a 32-bit shift register, clear the byte counter (0..BYTES_PER_WORD-1), go to ISSUE.
- ISSUE
  - tx_start=1 for exactly this cycle.
  - tx_data = shreg[31:24] + ASCII_OFFSET, 8-bit truncated.
  - Go to WAIT unconditionally.
- WAIT
  - Hold tx_data.
  - On tx_done with counter==BYTES_PER_WORD-1: go to DONE.
  - On tx_done otherwise: shift shreg left by 8, counter+1, go to ISSUE.
  - No tx_done: stay in WAIT indefinitely. There is no timeout.
- DONE
  - sent=1.
  - tx_address increments at the exit edge.
  - Go to IDLE.
- tx_done is ignored in IDLE, ISSUE and DONE.
- word_valid is ignored outside IDLE. A producer holding valid is accepted on its first IDLE cycle.
- word_data is sampled only on the accept edge. Later changes do not affect the word in flight.
- tx_data is registered and changes only at an ISSUE entry. Between words it holds the last transmitted byte.

## Timing
- Reset values:
  - state IDLE.
  - word_ready=1, busy=0, tx_start=0, sent=0.
  - tx_data=8'h00, tx_address=0, shreg=0, counter=0.
- Accept edge k: tx_start is high in cycle k+1 (ISSUE).
- tx_done in cycle n: next tx_start is in cycle n+1. Minimum inter-byte gap is 2 cycles (ISSUE + one WAIT cycle).
- Final tx_done in cycle n:
  - sent=1 in cycle n+1.
  - tx_address updates at the end of cycle n+1.
  - word_ready=1 in cycle n+2.
- Word throughput: a word occupies 2 + BYTES_PER_WORD·(1 + UART byte time) cycles.
- Reset mid-word: immediate return to IDLE; the partial word is discarded, with no sent and no address increment. A UART byte already in progress completes externally, and its tx_done is ignored.
- tx_address wraps from 32'hFFFFFFFF to 0.
- ASCII offset overflow wraps: byte 8'hFF with offset 48 gives 8'h2F.

## Structure
- Shared package `interfaz_pkg`:
  - FSM state typedef/localparams (IDLE, ISSUE, WAIT, DONE).
  - ASCII_OFFSET default (8'd48), shared with the receive interface.
  - WORD_W=32, BYTE_W=8.
- Single module with no sub-modules. Shift register, counter and FSM fit comfortably in one block.

## Test plan
- Single word 32'h01020304 with a UART model returning tx_done 10 cycles after each tx_start:
  - tx_data sequence 8'h31, 8'h32, 8'h33, 8'h34.
  - One sent pulse; tx_address=1.
- word_valid held high with two words, 32'h0A0B0C0D then 32'h00000000:
  - 8 bytes 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h30×4.
  - word_ready high only in IDLE cycles; tx_address=2.
- Spurious tx_done in IDLE and in the ISSUE cycle:
  - No state change and no extra bytes.
  - Byte count per word stays exactly 4.
- Reset asserted during WAIT of the 3rd byte of 32'hFFFFFFFF:
  - All outputs return to reset values; no sent pulse; tx_address=0.
  - A following word transmits correctly, with bytes 8'h2F (wrap case).
- Parameter variant BYTES_PER_WORD=2, ASCII_OFFSET=0, word 32'hDEADBEEF:
  - Bytes 8'hDE, 8'hAD only, then sent.
- tx_address preloaded near wrap (force to 32'hFFFFFFFF) and one word sent: tx_address=0.
